// File: rtl/flasher_defs.sv
// rtl/flasher_defs.sv - shared lamp-bus constants and sweep state encoding
package flasher_defs;

    localparam int N_LED = 16;
    localparam int LVL_W = 5;
    localparam int ERR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } state_t;

endpackage

// File: rtl/flasher_therm_dec.sv
// rtl/flasher_therm_dec.sv - combinational thermometer-code decoder for the lamp bus
module flasher_therm_dec #(
    parameter int N_LED = flasher_defs::N_LED,
    parameter int LVL_W = flasher_defs::LVL_W
) (
    input  logic [N_LED-1:0] led_q,
    output logic [LVL_W-1:0] lvl,
    output logic             legal
);

    logic [N_LED-1:0] inc;

    // 2^k-1 patterns are exactly those with no bit shared with their successor
    assign inc   = led_q + {{(N_LED-1){1'b0}}, 1'b1};
    assign legal = ((led_q & inc) == '0);

    always_comb begin
        lvl = '0;
        for (int i = 0; i < N_LED; i++) begin
            lvl = lvl + LVL_W'(led_q[i]);
        end
    end

endmodule

// File: rtl/flasher_led_decoder.sv
// rtl/flasher_led_decoder.sv - passive decoder of the flasher lamp bus: level, direction, turns, errors
module flasher_led_decoder
    import flasher_defs::*;
#(
    parameter int N_LED = flasher_defs::N_LED,
    parameter int LVL_W = flasher_defs::LVL_W,
    parameter int ERR_W = flasher_defs::ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_LED-1:0] led,
    output logic [LVL_W-1:0] level,
    output logic             rising,
    output logic             falling,
    output logic             peak_vld,
    output logic [LVL_W-1:0] peak_lvl,
    output logic             trough_vld,
    output logic [LVL_W-1:0] trough_lvl,
    output logic             blink_vld,
    output logic             code_err,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [LVL_W-1:0] FULL = LVL_W'(N_LED);

    logic [N_LED-1:0] led_q;
    logic [LVL_W-1:0] prev;
    logic [LVL_W-1:0] new_lvl;
    logic             legal;
    state_t           state, state_nxt;

    logic             is_blink, is_same, is_up, is_dn;
    logic [LVL_W-1:0] prev_nxt, peak_nxt, trough_nxt;
    logic             pk_nxt, tr_nxt, bl_nxt, ce_nxt, se_nxt;

    flasher_therm_dec #(
        .N_LED (N_LED),
        .LVL_W (LVL_W)
    ) u_dec (
        .led_q (led_q),
        .lvl   (new_lvl),
        .legal (legal)
    );

    assign is_blink = ((prev == '0) && (new_lvl == FULL)) || ((prev == FULL) && (new_lvl == '0));
    assign is_same  = (new_lvl == prev);
    assign is_up    = (new_lvl == prev + LVL_W'(1));
    assign is_dn    = (new_lvl + LVL_W'(1) == prev);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Blink and step errors abandon any sweep in progress
    always_comb begin
        state_nxt = state;
        if (legal && !is_same) begin
            if (is_blink) begin
                state_nxt = ST_IDLE;
            end else if (is_up) begin
                state_nxt = ST_RISE;
            end else if (is_dn) begin
                state_nxt = (state == ST_FALL && new_lvl == '0) ? ST_IDLE : ST_FALL;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        prev_nxt   = prev;
        peak_nxt   = peak_lvl;
        trough_nxt = trough_lvl;
        pk_nxt     = 1'b0;
        tr_nxt     = 1'b0;
        bl_nxt     = 1'b0;
        ce_nxt     = 1'b0;
        se_nxt     = 1'b0;
        if (!legal) begin
            ce_nxt = 1'b1;
        end else if (is_blink) begin
            bl_nxt   = 1'b1;
            prev_nxt = new_lvl;
        end else if (is_same) begin
            prev_nxt = prev;
        end else if (is_up) begin
            prev_nxt = new_lvl;
            if (state == ST_FALL) begin
                tr_nxt     = 1'b1;
                trough_nxt = prev;
            end
        end else if (is_dn) begin
            prev_nxt = new_lvl;
            if (state == ST_RISE) begin
                pk_nxt   = 1'b1;
                peak_nxt = prev;
            end else if (state == ST_FALL && new_lvl == '0) begin
                tr_nxt     = 1'b1;
                trough_nxt = '0;
            end
        end else begin
            se_nxt   = 1'b1;
            prev_nxt = new_lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q      <= '0;
            prev       <= '0;
            peak_lvl   <= '0;
            trough_lvl <= '0;
            peak_vld   <= 1'b0;
            trough_vld <= 1'b0;
            blink_vld  <= 1'b0;
            code_err   <= 1'b0;
            step_err   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            led_q      <= led;
            prev       <= prev_nxt;
            peak_lvl   <= peak_nxt;
            trough_lvl <= trough_nxt;
            peak_vld   <= pk_nxt;
            trough_vld <= tr_nxt;
            blink_vld  <= bl_nxt;
            code_err   <= ce_nxt;
            step_err   <= se_nxt;
            if ((ce_nxt || se_nxt) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

    assign level   = prev;
    assign rising  = (state == ST_RISE);
    assign falling = (state == ST_FALL);

endmodule
